mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder_pkg.sv | 47 ++++
 rtl/mem_bus_responder_ram.sv | 35 +++
 rtl/mem_bus_responder.sv | 159 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder_pkg
// Brief    : Address map, FSM and request encodings shared by the responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_responder_pkg;

   localparam logic [31:0] SW_ADDR  = 32'h0000_FFF0;
   localparam logic [31:0] LED_ADDR = 32'h0000_FFF1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_e;

   typedef enum logic [1:0] {
      RGN_RAM  = 2'd0,
      RGN_SW   = 2'd1,
      RGN_LED  = 2'd2,
      RGN_NONE = 2'd3
   } region_e;

   // Full 32-bit compare so high address bits never alias into RAM.
   function automatic region_e decode_region(input logic [31:0] addr,
                                             input logic [31:0] ram_words);
      region_e r;
      if (addr < ram_words) begin
         r = RGN_RAM;
      end else if (addr == SW_ADDR) begin
         r = RGN_SW;
      end else if (addr == LED_ADDR) begin
         r = RGN_LED;
      end else begin
         r = RGN_NONE;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : responder_ram
// Brief    : Single-port word RAM, synchronous write and synchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module responder_ram #(
   parameter int WORDS = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   // Storage is deliberately not reset; rdata holds until the next read.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Brief    : Wait-state memory/peripheral responder with RAM, SW and LED map.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int RAM_WORDS   = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Adress,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] MemData,
   output logic        isLocked,
   input  logic [31:0] SW,
   output logic [31:0] LED,
   output logic        BusError
);

   localparam int         AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   req_e        req_q;
   logic [31:0] mem_data_q;
   logic        ram_sel_q;
   logic [31:0] led_q;
   logic        bus_err_q;

   logic        w_req;
   logic        w_locked;
   logic        w_idle;
   logic [31:0] w_acc_addr;
   logic        w_acc_wr;
   region_e     w_region;
   logic        w_rd_fire;
   logic        w_wr_fire;
   logic [31:0] w_ram_rdata;

   assign w_req  = MemRead | MemWrite;
   assign w_idle = (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_locked = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               w_locked = 1'b1;
               cnt_d    = WAIT_LOAD;
               state_d  = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_locked = 1'b1;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign isLocked = w_locked;

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         req_q   <= REQ_READ;
      end else if (w_idle && w_req) begin
         addr_q  <= Adress;
         wdata_q <= WriteData;
         req_q   <= MemWrite ? REQ_WRITE : REQ_READ;
      end
   end

   // With zero wait states the read fires on the capture edge itself, so the
   // live request is decoded in IDLE and the captured copy everywhere else.
   assign w_acc_addr = w_idle ? Adress : addr_q;
   assign w_acc_wr   = w_idle ? MemWrite : (req_q == REQ_WRITE);
   assign w_region   = decode_region(w_acc_addr, 32'(RAM_WORDS));
   assign w_rd_fire  = (state_d == ST_DONE) && !w_acc_wr && !reset;
   assign w_wr_fire  = (state_q == ST_DONE) && (req_q == REQ_WRITE) && !reset;

   responder_ram #(
      .WORDS (RAM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_wr_fire && (w_region == RGN_RAM)),
      .re_i    (w_rd_fire && (w_region == RGN_RAM)),
      .addr_i  (w_acc_addr[AW-1:0]),
      .wdata_i (wdata_q),
      .rdata_o (w_ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_data_q <= 32'd0;
         ram_sel_q  <= 1'b0;
         led_q      <= 32'd0;
         bus_err_q  <= 1'b0;
      end else begin
         if (w_rd_fire) begin
            ram_sel_q <= (w_region == RGN_RAM);
            case (w_region)
               RGN_SW:  mem_data_q <= SW;
               RGN_LED: mem_data_q <= led_q;
               default: mem_data_q <= 32'd0;
            endcase
            if (w_region == RGN_NONE) begin
               bus_err_q <= 1'b1;
            end
         end
         if (w_wr_fire) begin
            if (w_region == RGN_LED) begin
               led_q <= wdata_q;
            end
            if (w_region == RGN_NONE) begin
               bus_err_q <= 1'b1;
            end
         end
      end
   end

   // Both sources are registers; the select only steers which one is visible.
   assign MemData  = ram_sel_q ? w_ram_rdata : mem_data_q;
   assign LED      = led_q;
   assign BusError = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Brief    : Directed self-checking bench for mem_bus_responder (WAIT 2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Adress, WriteData, SW;
   logic        MemRead, MemWrite;
   logic [31:0] MemData, LED;
   logic        isLocked, BusError;

   logic [31:0] Adress0, WriteData0, MemData0, LED0;
   logic        MemRead0, MemWrite0, isLocked0, BusError0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mem_bus_responder #(.WAIT_CYCLES(2), .RAM_WORDS(256)) dut (
      .clk       (clk),
      .reset     (reset),
      .Adress    (Adress),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemData   (MemData),
      .isLocked  (isLocked),
      .SW        (SW),
      .LED       (LED),
      .BusError  (BusError)
   );

   mem_bus_responder #(.WAIT_CYCLES(0), .RAM_WORDS(256)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .Adress    (Adress0),
      .WriteData (WriteData0),
      .MemRead   (MemRead0),
      .MemWrite  (MemWrite0),
      .MemData   (MemData0),
      .isLocked  (isLocked0),
      .SW        (SW),
      .LED       (LED0),
      .BusError  (BusError0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Starts in IDLE just after a rising edge; returns likewise after DONE.
   task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic scramble,
                            output logic [31:0] rdata, output int locks);
      bit done = 0;
      Adress = addr; WriteData = wdata; MemWrite = wr; MemRead = rd;
      locks = 0; rdata = 32'd0;
      for (int g = 0; g < 20 && !done; g++) begin
         @(negedge clk);
         if (isLocked) begin
            locks++;
            if (scramble && locks == 2) begin
               Adress = 32'h3; WriteData = 32'h99;
            end
         end else begin
            rdata = MemData; done = 1;
            MemWrite = 1'b0; MemRead = 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("access_done", 32'(done), 32'd1);
   endtask

   logic [31:0] rd;
   int          lk;

   initial begin
      reset = 1'b1; SW = 32'h0000_00A5;
      Adress = '0; WriteData = '0; MemRead = 0; MemWrite = 0;
      Adress0 = '0; WriteData0 = '0; MemRead0 = 0; MemWrite0 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_memdata", MemData, 32'd0);
      chk("rst_led", LED, 32'd0);
      chk("rst_buserr", 32'(BusError), 32'd0);
      chk("rst_locked", 32'(isLocked), 32'd0);
      chk("rst_memdata0", MemData0, 32'd0);
      chk("rst_locked0", 32'(isLocked0), 32'd0);
      @(posedge clk); #1;

      do_access(1, 0, 32'h10, 32'hDEADBEEF, 0, rd, lk);
      chk("wr10_locks", 32'(lk), 32'd3);
      do_access(0, 1, 32'h10, 32'h0, 0, rd, lk);
      chk("rd10_locks", 32'(lk), 32'd3);
      chk("rd10_data", rd, 32'hDEADBEEF);

      do_access(0, 1, 32'hFFF0, 32'h0, 0, rd, lk);
      chk("rd_sw", rd, 32'h0000_00A5);
      do_access(1, 0, 32'hFFF1, 32'h3C, 0, rd, lk);
      chk("led_after_wr", LED, 32'h3C);
      do_access(0, 1, 32'hFFF1, 32'h0, 0, rd, lk);
      chk("rd_led", rd, 32'h3C);

      do_access(1, 0, 32'hFFF0, 32'h123, 0, rd, lk);
      chk("wr_sw_no_err", 32'(BusError), 32'd0);
      do_access(0, 1, 32'hFFF0, 32'h0, 0, rd, lk);
      chk("rd_sw_again", rd, 32'h0000_00A5);

      do_access(1, 0, 32'hFF, 32'hCAFE0001, 0, rd, lk);
      do_access(0, 1, 32'hFF, 32'h0, 0, rd, lk);
      chk("rd_last_word", rd, 32'hCAFE0001);

      do_access(0, 1, 32'h0001_0000, 32'h0, 0, rd, lk);
      chk("rd_unmapped", rd, 32'd0);
      chk("err_set", 32'(BusError), 32'd1);
      do_access(0, 1, 32'h10, 32'h0, 0, rd, lk);
      chk("rd_after_err", rd, 32'hDEADBEEF);
      chk("err_sticky", 32'(BusError), 32'd1);

      // Abort a RAM write in WAIT, then another in DONE.
      do_access(1, 0, 32'h5, 32'h11, 0, rd, lk);
      MemWrite = 1; Adress = 32'h5; WriteData = 32'h77;
      @(posedge clk); #1;
      reset = 1'b1; MemWrite = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_wait_idle", 32'(isLocked), 32'd0);
      chk("abort_led", LED, 32'd0);
      chk("abort_err_clr", 32'(BusError), 32'd0);
      @(posedge clk); #1;
      MemWrite = 1; Adress = 32'h5; WriteData = 32'h88;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1; MemWrite = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      do_access(0, 1, 32'h5, 32'h0, 0, rd, lk);
      chk("abort_ram5", rd, 32'h11);

      do_access(0, 1, 32'h8000_0010, 32'h0, 0, rd, lk);
      chk("rd_alias", rd, 32'd0);
      chk("alias_err", 32'(BusError), 32'd1);
      pulse_reset();
      do_access(1, 0, 32'h100, 32'h5, 0, rd, lk);
      chk("wr_unmapped_err", 32'(BusError), 32'd1);

      do_access(1, 0, 32'h3, 32'h33, 0, rd, lk);
      do_access(0, 1, 32'h3, 32'h0, 0, rd, lk);
      chk("rd3", rd, 32'h33);
      do_access(1, 1, 32'h7, 32'h55, 1, rd, lk);
      chk("both_no_read", rd, 32'h33);
      chk("both_locks", 32'(lk), 32'd3);
      do_access(0, 1, 32'h7, 32'h0, 0, rd, lk);
      chk("rd7", rd, 32'h55);
      do_access(0, 1, 32'h3, 32'h0, 0, rd, lk);
      chk("rd3_untouched", rd, 32'h33);

      // Zero wait states, request held across back-to-back accesses.
      for (int i = 0; i < 2; i++) begin
         MemWrite0 = 1; Adress0 = 32'(i); WriteData0 = 32'hA0 + 32'(i);
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      MemWrite0 = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         MemRead0 = 1; Adress0 = 32'(i);
         @(negedge clk);
         chk($sformatf("b2b_lock_%0d", i), 32'(isLocked0), 32'd1);
         @(posedge clk); #1;
         Adress0 = 32'h40;
         @(negedge clk);
         chk($sformatf("b2b_unlock_%0d", i), 32'(isLocked0), 32'd0);
         chk($sformatf("b2b_data_%0d", i), MemData0, 32'hA0 + 32'(i));
         @(posedge clk); #1;
      end
      MemRead0 = 0;
      @(negedge clk);
      chk("b2b_err", 32'(BusError0), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
